// File: rtl/sequence_round_engine.sv
// rtl/sequence_round_engine.sv - memory-game round controller: playback then checking of player presses
//
// Drives the address of a 16x4 registered-read sequence RAM, plays entries 0..limit
// on the LEDs, then checks the player's button presses against the same entries.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   begin a round (sampled only in IDLE)
//   limit      in   index of last entry of the round, sampled at start
//   buttons    in   player buttons, level, synchronised/debounced
//   ram_addr   out  registered RAM address
//   ram_q      in   RAM data, valid one clock after ram_addr changes
//   leds       out  colour display
//   busy       out  high in every state except IDLE
//   round_ok   out  1-clk pulse, all entries matched
//   round_err  out  1-clk pulse, wrong press
//   timeout    out  1-clk pulse, no press in time
//   err_index  out  index of the failing entry, held until next start
module sequence_round_engine #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 4,
    parameter int SHOW_CYCLES    = 1000,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] limit,
    input  logic [DATA_W-1:0] buttons,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] leds,
    output logic              busy,
    output logic              round_ok,
    output logic              round_err,
    output logic              timeout,
    output logic [ADDR_W-1:0] err_index
);

    typedef enum logic [2:0] {
        IDLE, S_FETCH, S_ON, S_OFF, I_FETCH, I_WAIT, I_RELEASE
    } state_t;

    localparam int MAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] lim;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] btn_prev;
    logic              press;

    // Only a 0 -> non-zero transition counts, so buttons held across the
    // entry into I_WAIT are ignored until released and pressed again.
    assign press = (buttons != '0) && (btn_prev == '0);

    // ram_q is itself registered and the state is registered, so the LED
    // value is a clean function of flops and shows exactly while in S_ON.
    assign leds = (state == S_ON) ? ram_q : '0;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            lim       <= '0;
            cnt       <= '0;
            ram_addr  <= '0;
            btn_prev  <= '0;
            round_ok  <= 1'b0;
            round_err <= 1'b0;
            timeout   <= 1'b0;
            err_index <= '0;
        end else begin
            round_ok  <= 1'b0;
            round_err <= 1'b0;
            timeout   <= 1'b0;
            btn_prev  <= buttons;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        lim       <= limit;
                        ram_addr  <= '0;
                        err_index <= '0;
                        cnt       <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    cnt   <= '0;
                    state <= S_ON;
                end
                S_ON: begin
                    if (cnt == CNT_W'(SHOW_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OFF: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (idx == lim) begin
                            idx      <= '0;
                            ram_addr <= '0;
                            state    <= I_FETCH;
                        end else begin
                            idx      <= idx + 1'b1;
                            ram_addr <= idx + 1'b1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                I_FETCH: begin
                    cnt   <= '0;
                    state <= I_WAIT;
                end
                I_WAIT: begin
                    if (press) begin
                        if (buttons == ram_q) begin
                            state <= I_RELEASE;
                        end else begin
                            err_index <= idx;
                            round_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_index <= idx;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                I_RELEASE: begin
                    if (buttons == '0) begin
                        if (idx == lim) begin
                            round_ok <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx      <= idx + 1'b1;
                            ram_addr <= idx + 1'b1;
                            state    <= I_FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_round_engine.sv
// tb/tb_sequence_round_engine.sv - self-checking bench for sequence_round_engine
module tb_sequence_round_engine;

    localparam int SHOW = 3;
    localparam int GAP  = 2;
    localparam int TO   = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] limit = '0;
    logic [3:0] buttons = '0;
    logic [3:0] ram_addr;
    logic [3:0] ram_q = '0;
    logic [3:0] leds;
    logic       busy, round_ok, round_err, timeout;
    logic [3:0] err_index;

    logic [3:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]       lim;
        logic [15:0][3:0] seq;
        int               npress;
        logic [15:0][3:0] press;
        logic [2:0]       pulses;   // expected {round_ok, round_err, timeout}
        logic [3:0]       eidx;
        bit               start_mid;
    } vec_t;

    typedef struct {
        logic [2:0] pulses;
        logic [3:0] eidx;
    } out_t;

    typedef struct {
        logic [3:0] leds;
        logic [3:0] addr;
    } pb_t;

    vec_t tbl [8];
    out_t exp_q [$];
    pb_t  pb_q [$];
    out_t mon_e;

    sequence_round_engine #(
        .ADDR_W(4), .DATA_W(4),
        .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .limit(limit),
        .buttons(buttons), .ram_addr(ram_addr), .ram_q(ram_q),
        .leds(leds), .busy(busy), .round_ok(round_ok),
        .round_err(round_err), .timeout(timeout), .err_index(err_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pulse scoreboard: every outcome pulse must match the next expected outcome.
    always @(negedge clk) begin
        if (!reset && (round_ok || round_err || timeout)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, round_ok, round_err, timeout}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse", {29'd0, round_ok, round_err, timeout}, {29'd0, mon_e.pulses});
                chk("pulse_err_index", {28'd0, err_index}, {28'd0, mon_e.eidx});
                chk("pulse_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] l, input int np, input logic [2:0] p,
                                input logic [3:0] e, input bit mid);
        vec_t v;
        v.lim = l; v.seq = '0; v.npress = np; v.press = '0;
        v.pulses = p; v.eidx = e; v.start_mid = mid;
        return v;
    endfunction

    task automatic do_start(input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        limit = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of the first S_FETCH; returns at the I_FETCH negedge.
    task automatic drain(input logic [3:0] l, input bit mid);
        int j;
        pb_t p;
        pb_q.delete();
        for (int i = 0; i <= int'(l); i++) begin
            pb_q.push_back('{4'd0, 4'(i)});
            for (int s = 0; s < SHOW; s++) pb_q.push_back('{mem[i], 4'(i)});
            for (int g = 0; g < GAP; g++) pb_q.push_back('{4'd0, 4'(i)});
        end
        j = 0;
        while (pb_q.size() > 0) begin
            p = pb_q.pop_front();
            chk("playback", {23'd0, busy, leds, ram_addr}, {23'd0, 1'b1, p.leds, p.addr});
            if (mid && j == 4) begin
                start = 1'b1;
                limit = 4'd0;
            end else begin
                start = 1'b0;
            end
            j++;
            @(negedge clk);
        end
        chk("ifetch_state", {23'd0, busy, leds, ram_addr}, {23'd0, 1'b1, 4'd0, 4'd0});
    endtask

    // Called in I_FETCH; returns at the negedge after the release was sampled.
    task automatic press(input logic [3:0] v, input int h);
        @(negedge clk);
        buttons = v;
        repeat (h) @(negedge clk);
        buttons = '0;
        @(negedge clk);
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_bound", 32'd1, 32'd0);
    endtask

    initial begin
        int k;
        vec_t v;

        for (int i = 0; i < 16; i++) mem[i] = '0;

        tbl[0] = mk(4'd1, 2, 3'b100, 4'd0, 1'b0);
        tbl[0].seq[0] = 4'b0010; tbl[0].seq[1] = 4'b0001;
        tbl[0].press[0] = 4'b0010; tbl[0].press[1] = 4'b0001;
        tbl[1] = mk(4'd1, 1, 3'b010, 4'd0, 1'b0);
        tbl[1].seq = tbl[0].seq; tbl[1].press[0] = 4'b0100;
        tbl[2] = mk(4'd1, 2, 3'b010, 4'd1, 1'b0);
        tbl[2].seq = tbl[0].seq; tbl[2].press[0] = 4'b0010; tbl[2].press[1] = 4'b0011;
        tbl[3] = mk(4'd1, 0, 3'b001, 4'd0, 1'b1);
        tbl[3].seq = tbl[0].seq;
        tbl[4] = mk(4'd15, 16, 3'b100, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tbl[4].seq[i] = 4'b1000;
            tbl[4].press[i] = 4'b1000;
        end
        tbl[5] = mk(4'd0, 1, 3'b100, 4'd0, 1'b0);
        tbl[5].seq[0] = 4'b0100; tbl[5].press[0] = 4'b0100;
        tbl[6] = mk(4'd2, 3, 3'b010, 4'd2, 1'b0);
        tbl[6].seq[0] = 4'b0001; tbl[6].seq[1] = 4'b0010; tbl[6].seq[2] = 4'b0100;
        tbl[6].press[0] = 4'b0001; tbl[6].press[1] = 4'b0010; tbl[6].press[2] = 4'b1000;
        tbl[7] = mk(4'd1, 1, 3'b001, 4'd1, 1'b0);
        tbl[7].seq = tbl[0].seq; tbl[7].press[0] = 4'b0010;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {13'd0, busy, round_ok, round_err, timeout, leds, ram_addr, err_index},
            32'd0);

        // Reset held two clocks in the middle of S_ON aborts silently
        mem[0] = 4'b0010; mem[1] = 4'b0001;
        do_start(4'd1);
        k = 0;
        while (leds == '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reached_s_on", {28'd0, leds}, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("mid_reset", {23'd0, busy, leds, ram_addr}, 32'd0);
        @(negedge clk);
        chk("mid_reset_stays_idle", {23'd0, busy, leds, ram_addr}, 32'd0);

        // Table-driven rounds
        for (int r = 0; r < 8; r++) begin
            v = tbl[r];
            for (int i = 0; i < 16; i++) mem[i] = v.seq[i];
            do_start(v.lim);
            drain(v.lim, v.start_mid);
            exp_q.push_back('{v.pulses, v.eidx});
            for (int p = 0; p < v.npress; p++) press(v.press[p], 2);
            wait_idle(k);
            if (v.pulses == 3'b001) chk("timeout_latency", k, TO + 1);
            repeat (3) @(negedge clk);
            chk("outcome_seen", exp_q.size(), 32'd0);
            chk("err_index_held", {28'd0, err_index}, {28'd0, v.eidx});
            chk("idle_after", {31'd0, busy}, 32'd0);
        end

        // Buttons held on entry to I_WAIT do not count until re-pressed
        mem[0] = 4'b0100;
        do_start(4'd0);
        drain(4'd0, 1'b0);
        buttons = 4'b0100;
        repeat (4) @(negedge clk);
        chk("held_ignored", {31'd0, busy}, 32'd1);
        buttons = '0;
        @(negedge clk);
        exp_q.push_back('{3'b100, 4'd0});
        press(4'b0100, 1);
        wait_idle(k);
        repeat (2) @(negedge clk);
        chk("held_then_ok", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
